// File: rtl/hex_capture_pkg.sv
// hex_capture_pkg: shared types and constants for the seven-segment capture block.
// Holds the capture FSM states, the active-low glyph table (bits 6:0 = g..a)
// and the helper that sizes the stability counter.
package hex_capture_pkg;

   // FSM encodings kept as plain constants so older code can still use them
   localparam logic [0:0] ST_SETTLE = 1'b0;
   localparam logic [0:0] ST_REPORT = 1'b1;

   typedef enum logic [0:0] {
      SETTLE = ST_SETTLE,
      REPORT = ST_REPORT
   } state_t;

   // Active-low glyphs, segment a in bit 0
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h18;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Counter must hold values 0..stable_cycles inclusive
   function automatic int cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/hex_capture_seg7_decode.sv
// seg7_decode: combinational inverse of the hex-to-segment encoder for one digit.
// Unknown non-blank patterns flag err and return nibble 0. The dp output only
// reflects the input when DP_EN is set; otherwise it is held at 0.
module seg7_decode
   import hex_capture_pkg::*;
#(
   parameter bit DP_EN = 1'b0
) (
   input  logic [7:0] seg_in,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       err,
   output logic       dp
);

   // Map the seven active-low segment lines back to a hex nibble
   always_comb begin
      nibble = 4'h0;
      blank  = 1'b0;
      err    = 1'b0;
      dp     = DP_EN ? ~seg_in[7] : 1'b0;
      case (seg_in[6:0])
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/hex_capture.sv
// hex_capture: samples the six active-low seven-segment buses, waits until the
// bus has been identical for STABLE_CYCLES samples, then offers the decoded
// snapshot on a valid/ready handshake. Re-reports of an unchanged bus are
// suppressed except for the first snapshot after reset.
// Build option HEX_CAPTURE_DP_EN: when defined, the decimal-point bit is
// sampled and reported; otherwise it is forced off before sampling.
module hex_capture
   import hex_capture_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [8*NUM_DIGITS-1:0] hex_in,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [4*NUM_DIGITS-1:0] out_value,
   output logic [NUM_DIGITS-1:0]   out_blank,
   output logic [NUM_DIGITS-1:0]   out_err,
   output logic [NUM_DIGITS-1:0]   out_dp
);

   localparam int             HW      = 8 * NUM_DIGITS;
   localparam int             VW      = 4 * NUM_DIGITS;
   localparam int             CW      = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);
`ifdef HEX_CAPTURE_DP_EN
   localparam bit             DP_EN   = 1'b1;
`else
   localparam bit             DP_EN   = 1'b0;
`endif

   logic [HW-1:0]         hex_masked;
   logic [HW-1:0]         s0_q, s0_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   state_t                state_q, state_d;
   logic                  first_q, first_d;
   logic [HW-1:0]         last_rep_q, last_rep_d;
   logic [HW-1:0]         rep_pat_q, rep_pat_d;
   logic [VW-1:0]         value_q, value_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic [NUM_DIGITS-1:0] err_q, err_d;
   logic [NUM_DIGITS-1:0] dp_q, dp_d;

   logic [VW-1:0]         dec_value;
   logic [NUM_DIGITS-1:0] dec_blank;
   logic [NUM_DIGITS-1:0] dec_err;
   logic [NUM_DIGITS-1:0] dec_dp;

   // Force dp lines off when the decimal point is not part of the snapshot
   always_comb begin
      hex_masked = hex_in;
      if (!DP_EN) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_masked[8*i+7] = 1'b1;
         end
      end else begin
         hex_masked = hex_in;
      end
   end

   // Per-digit decoders always look at the settled sample register
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg7_decode #(
         .DP_EN (DP_EN)
      ) u_dec (
         .seg_in (s0_q[8*g +: 8]),
         .nibble (dec_value[4*g +: 4]),
         .blank  (dec_blank[g]),
         .err    (dec_err[g]),
         .dp     (dec_dp[g])
      );
   end

   // Stability tracking: restart on any change, otherwise count up and saturate
   always_comb begin
      s0_d  = s0_q;
      cnt_d = cnt_q;
      if (hex_masked != s0_q) begin
         s0_d  = hex_masked;
         cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Snapshot FSM: load a settled, new pattern and hold it until accepted
   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      last_rep_d = last_rep_q;
      rep_pat_d  = rep_pat_q;
      value_d    = value_q;
      blank_d    = blank_q;
      err_d      = err_q;
      dp_d       = dp_q;
      case (state_q)
         SETTLE: begin
            if ((cnt_q == CNT_MAX) && (first_q || (s0_q != last_rep_q))) begin
               rep_pat_d = s0_q;
               value_d   = dec_value;
               blank_d   = dec_blank;
               err_d     = dec_err;
               dp_d      = dec_dp;
               state_d   = REPORT;
            end else begin
               state_d   = SETTLE;
            end
         end
         REPORT: begin
            if (out_ready) begin
               last_rep_d = rep_pat_q;
               first_d    = 1'b0;
               state_d    = SETTLE;
            end else begin
               state_d    = REPORT;
            end
         end
         default: begin
            state_d = SETTLE;
         end
      endcase
   end

   // State and output registers; reset drops any pending snapshot at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_q       <= {HW{1'b1}};
         cnt_q      <= {CW{1'b0}};
         state_q    <= SETTLE;
         first_q    <= 1'b1;
         last_rep_q <= {HW{1'b1}};
         rep_pat_q  <= {HW{1'b1}};
         value_q    <= {VW{1'b0}};
         blank_q    <= {NUM_DIGITS{1'b0}};
         err_q      <= {NUM_DIGITS{1'b0}};
         dp_q       <= {NUM_DIGITS{1'b0}};
      end else begin
         s0_q       <= s0_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         first_q    <= first_d;
         last_rep_q <= last_rep_d;
         rep_pat_q  <= rep_pat_d;
         value_q    <= value_d;
         blank_q    <= blank_d;
         err_q      <= err_d;
         dp_q       <= dp_d;
      end
   end

   assign out_valid = (state_q == REPORT);
   assign out_value = value_q;
   assign out_blank = blank_q;
   assign out_err   = err_q;
   assign out_dp    = dp_q;

endmodule
